// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: owns the player position and heading and updates them
// once per frame tick from four movement keys. Wall collisions are resolved
// against a 16x16 maze ROM (64 world units per cell) with axis sliding.
// Outputs change only at a commit, so they stay stable while a frame is drawn.
//
// Ports:
//   clock, resetn           system clock, async active-low reset
//   frame_tick              frame-rate level; its rising edge starts an update
//   move_fwd, move_back     step along / against the heading
//   turn_left, turn_right   heading +1 / -1 (mod 32)
//   map_addr, map_data      map ROM address {cellY, cellX}; wall bit, 1-cycle latency
//   playerX, playerY        committed position, 0..1023
//   angle_X, angle_Y        COS/SIN of the heading, Q2.8
//   update_done             one-cycle pulse at the end of each update
//   busy                    high whenever an update is in progress
module player_motion_ctrl #(
  parameter int START_X       = 96,
  parameter int START_Y       = 96,
  parameter int START_HEADING = 0,
  parameter int STEP_SHIFT    = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               move_fwd,
  input  logic               move_back,
  input  logic               turn_left,
  input  logic               turn_right,
  output logic [7:0]         map_addr,
  input  logic               map_data,
  output logic signed [12:0] playerX,
  output logic signed [12:0] playerY,
  output logic signed [9:0]  angle_X,
  output logic signed [9:0]  angle_Y,
  output logic               update_done,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN, S_CAND, S_READ, S_CHECK, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic               tick_q, tick_rise;
  logic               fwd_only, back_only;
  logic [4:0]         heading, heading_nx;
  logic [1:0]         attempt;
  logic signed [12:0] cand_x, cand_y;
  logic signed [12:0] att_x, att_y;
  logic signed [12:0] dir_x, dir_y, step_x, step_y;
  logic               att_ok;

  // round(256*sin(2*pi*h/32)) built from a quarter-wave table.
  function automatic logic signed [9:0] sin_lut(input logic [4:0] h);
    logic [3:0]         k;
    logic signed [9:0]  m;
    k = h[3:0];
    if (k > 4'd8) k = 4'd0 - k;
    case (k)
      4'd0:    m = 10'sd0;
      4'd1:    m = 10'sd50;
      4'd2:    m = 10'sd98;
      4'd3:    m = 10'sd142;
      4'd4:    m = 10'sd181;
      4'd5:    m = 10'sd213;
      4'd6:    m = 10'sd237;
      4'd7:    m = 10'sd251;
      default: m = 10'sd256;
    endcase
    return h[4] ? -m : m;
  endfunction

  function automatic logic signed [9:0] cos_lut(input logic [4:0] h);
    return sin_lut(h + 5'd8);
  endfunction

  assign tick_rise = frame_tick & ~tick_q;
  assign fwd_only  = move_fwd & ~move_back;
  assign back_only = move_back & ~move_fwd;

  always_comb begin
    heading_nx = heading;
    if (turn_left && !turn_right)      heading_nx = heading + 5'd1;
    else if (turn_right && !turn_left) heading_nx = heading - 5'd1;
  end

  // Backward motion negates the vector before the floor shift, so it is the
  // same step as moving forward along the opposite heading.
  always_comb begin
    dir_x = {{3{angle_X[9]}}, angle_X};
    dir_y = {{3{angle_Y[9]}}, angle_Y};
    if (back_only) begin
      dir_x = -dir_x;
      dir_y = -dir_y;
    end
    step_x = dir_x >>> STEP_SHIFT;
    step_y = dir_y >>> STEP_SHIFT;
  end

  // Attempt order: full move, X only, Y only.
  always_comb begin
    case (attempt)
      2'd0: begin
        att_x = cand_x;
        att_y = cand_y;
      end
      2'd1: begin
        att_x = cand_x;
        att_y = playerY;
      end
      default: begin
        att_x = playerX;
        att_y = cand_y;
      end
    endcase
    att_ok = (att_x[12:10] == 3'b000) && (att_y[12:10] == 3'b000) &&
             !((att_x == playerX) && (att_y == playerY));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (tick_rise) state_nx = S_TURN;
      S_TURN:  state_nx = S_CAND;
      S_CAND:  state_nx = (fwd_only || back_only) ? S_READ : S_DONE;
      S_READ: begin
        if (att_ok)                 state_nx = S_CHECK;
        else if (attempt == 2'd2)   state_nx = S_DONE;
      end
      S_CHECK: begin
        if (!map_data || attempt == 2'd2) state_nx = S_DONE;
        else                              state_nx = S_READ;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The address is presented during S_READ so the synchronous ROM output is
  // valid throughout S_CHECK.
  always_comb begin
    busy        = (state != S_IDLE);
    update_done = (state == S_DONE);
    map_addr    = '0;
    if (state == S_READ) map_addr = {att_y[9:6], att_x[9:6]};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_q  <= 1'b0;
      heading <= 5'(START_HEADING);
      angle_X <= cos_lut(5'(START_HEADING));
      angle_Y <= sin_lut(5'(START_HEADING));
      playerX <= 13'(START_X);
      playerY <= 13'(START_Y);
      cand_x  <= '0;
      cand_y  <= '0;
      attempt <= '0;
    end else begin
      tick_q <= frame_tick;
      case (state)
        S_TURN: begin
          heading <= heading_nx;
          angle_X <= cos_lut(heading_nx);
          angle_Y <= sin_lut(heading_nx);
        end
        S_CAND: begin
          cand_x  <= playerX + step_x;
          cand_y  <= playerY + step_y;
          attempt <= '0;
        end
        S_READ: begin
          if (!att_ok) attempt <= attempt + 2'd1;
        end
        S_CHECK: begin
          if (!map_data) begin
            playerX <= att_x;
            playerY <= att_y;
          end else begin
            attempt <= attempt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
module tb_player_motion_ctrl;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               frame_tick = 1'b0;
  logic               move_fwd = 1'b0;
  logic               move_back = 1'b0;
  logic               turn_left = 1'b0;
  logic               turn_right = 1'b0;
  logic [7:0]         map_addr;
  logic               map_data = 1'b0;
  logic signed [12:0] playerX, playerY;
  logic signed [9:0]  angle_X, angle_Y;
  logic               update_done, busy;

  logic map_mem [256];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int done_count = 0;

  typedef struct {
    int x;
    int y;
    int ax;
    int ay;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_lat;

  player_motion_ctrl #(
    .START_X(96),
    .START_Y(96),
    .START_HEADING(0),
    .STEP_SHIFT(4)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .frame_tick(frame_tick),
    .move_fwd(move_fwd),
    .move_back(move_back),
    .turn_left(turn_left),
    .turn_right(turn_right),
    .map_addr(map_addr),
    .map_data(map_data),
    .playerX(playerX),
    .playerY(playerY),
    .angle_X(angle_X),
    .angle_Y(angle_Y),
    .update_done(update_done),
    .busy(busy)
  );

  always #10 clock = ~clock;

  // Synchronous map ROM model and cycle counter.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    map_data <= map_mem[map_addr];
  end

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Monitor: every update_done pops one expected result.
  always @(negedge clock) begin
    if (resetn && update_done) begin
      done_count++;
      mon_lat = cyc - tick_cyc;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got update_done=1 with nothing pending, expected 0");
      end else begin
        mon_e = sb_q.pop_front();
        chk("playerX", int'(playerX), mon_e.x);
        chk("playerY", int'(playerY), mon_e.y);
        chk("angle_X", int'(angle_X), mon_e.ax);
        chk("angle_Y", int'(angle_Y), mon_e.ay);
        if (mon_e.lat >= 0) chk("latency", mon_lat, mon_e.lat);
        n_checks++;
        if (mon_lat <= 9) n_pass++;
        else $display("FAIL latency_bound: got %0d cycles, expected <= 9", mon_lat);
      end
    end
  end

  task automatic do_tick(input logic f, input logic b, input logic l, input logic r,
                         input int ex, input int ey, input int eax, input int eay,
                         input int elat);
    int start_done;
    int waited;
    @(negedge clock);
    move_fwd   = f;
    move_back  = b;
    turn_left  = l;
    turn_right = r;
    sb_q.push_back('{ex, ey, eax, eay, elat});
    start_done = done_count;
    tick_cyc   = cyc;
    frame_tick = 1'b1;
    waited = 0;
    while (done_count == start_done && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (done_count == start_done) begin
      n_checks++;
      $display("FAIL done_timeout: got no update_done in 20 cycles, expected one");
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    frame_tick = 1'b0;
    move_fwd   = 1'b0;
    move_back  = 1'b0;
    turn_left  = 1'b0;
    turn_right = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_playerX"}, int'(playerX), 96);
    chk({tag, "_playerY"}, int'(playerY), 96);
    chk({tag, "_angle_X"}, int'(angle_X), 256);
    chk({tag, "_angle_Y"}, int'(angle_Y), 0);
    chk({tag, "_map_addr"}, int'(map_addr), 0);
    chk({tag, "_update_done"}, int'(update_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int x;
    int nx;
    int start_done;
    int ang_x [4];
    int ang_y [4];
    ang_x = '{251, 237, 213, 181};
    ang_y = '{50, 98, 142, 181};

    for (int unsigned i = 0; i < 256; i++) map_mem[i] = 1'b0;

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Free move, turns, and the "both keys" cases.
    do_tick(1, 0, 0, 0, 112, 96, 256, 0, 5);
    do_tick(0, 0, 0, 1, 112, 96, 251, -50, 3);
    do_tick(0, 0, 1, 0, 112, 96, 256, 0, 3);
    do_tick(1, 1, 0, 0, 112, 96, 256, 0, 3);
    do_tick(0, 0, 1, 1, 112, 96, 256, 0, 3);

    // Wall in cell (2,1): blocked head-on, then sliding along Y.
    map_mem[8'h12] = 1'b1;
    do_tick(1, 0, 0, 0, 112, 96, 256, 0, 8);
    do_tick(1, 0, 1, 0, 127, 99, 251, 50, 5);
    do_tick(1, 0, 1, 0, 127, 105, 237, 98, 9);
    do_tick(1, 0, 1, 0, 127, 113, 213, 142, 9);
    do_tick(1, 0, 1, 0, 127, 124, 181, 181, 9);
    do_tick(0, 1, 0, 0, 115, 112, 181, 181, 5);
    // Own cell walled too: all three attempts blocked.
    map_mem[8'h11] = 1'b1;
    do_tick(1, 0, 0, 0, 115, 112, 181, 181, 9);
    map_mem[8'h11] = 1'b0;
    map_mem[8'h12] = 1'b0;

    // Reset while in S_CHECK of a turn+move: no commit, heading restored.
    @(negedge clock);
    move_fwd   = 1'b1;
    turn_left  = 1'b1;
    frame_tick = 1'b1;
    repeat (3) @(negedge clock);
    chk("read_map_addr", int'(map_addr), 8'h11);
    @(negedge clock);
    chk("busy_in_check", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("abort");
    frame_tick = 1'b0;
    move_fwd   = 1'b0;
    turn_left  = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_hold_playerX", int'(playerX), 96);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Turn to heading 4, then step back: floor(-181/16) = -12.
    for (int i = 0; i < 4; i++) do_tick(0, 0, 1, 0, 96, 96, ang_x[i], ang_y[i], 3);
    do_tick(0, 1, 0, 0, 84, 84, 181, 181, 5);

    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // A second tick edge while busy must not start another update.
    @(negedge clock);
    move_fwd = 1'b1;
    sb_q.push_back('{112, 96, 256, 0, 5});
    start_done = done_count;
    tick_cyc   = cyc;
    frame_tick = 1'b1;
    @(negedge clock);
    chk("busy_in_turn", int'(busy), 1);
    @(negedge clock);
    frame_tick = 1'b0;
    @(negedge clock);
    frame_tick = 1'b1;
    repeat (12) @(negedge clock);
    frame_tick = 1'b0;
    move_fwd   = 1'b0;
    repeat (2) @(negedge clock);
    chk("dones_per_edge", done_count - start_done, 1);

    // Lower X boundary: -16 is out of range.
    x = 112;
    for (int i = 0; i < 8; i++) begin
      nx = x - 16;
      if (nx >= 0) begin
        x = nx;
        do_tick(0, 1, 0, 0, x, 96, 256, 0, 5);
      end else begin
        do_tick(0, 1, 0, 0, x, 96, 256, 0, 6);
      end
    end

    // Upper X boundary: 1024 is out of range.
    for (int i = 0; i < 64; i++) begin
      nx = x + 16;
      if (nx <= 1023) begin
        x = nx;
        do_tick(1, 0, 0, 0, x, 96, 256, 0, 5);
      end else begin
        do_tick(1, 0, 0, 0, x, 96, 256, 0, 6);
      end
    end
    chk("final_playerX", int'(playerX), 1008);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Upstream stage of draw_frame. It owns the player's position and heading, and updates them once per frame tick from four movement keys. Wall collisions are resolved against a 16x16 maze map ROM, with axis sliding. Its outputs drive the playerX, playerY, angle_X and angle_Y inputs of draw_frame, and change only at a commit, so they are stable while a frame is drawn.

Parameters:
START_X, 96, reset X position (world units, 64 per map cell)
START_Y, 96, reset Y position
START_HEADING, 0, reset heading index (0..31)
STEP_SHIFT, 4, arithmetic right shift applied to the direction vector to form the per-frame step

Ports:
clock  in  1  system clock (50 MHz)
resetn  in  1  asynchronous, active-low reset
frame_tick  in  1  frame-rate level signal (same net as draw_frame clock60Hz); its rising edge starts an update
move_fwd  in  1  level: step along the heading
move_back  in  1  level: step against the heading
turn_left  in  1  level: heading +1 (counter-clockwise)
turn_right  in  1  level: heading -1
map_addr  out  8  map ROM address {cellY[3:0], cellX[3:0]}
map_data  in  1  wall bit from a synchronous ROM; 1-cycle latency after map_addr
playerX  out  13 signed  committed X position, range 0..1023
playerY  out  13 signed  committed Y position, range 0..1023
angle_X  out  10 signed  COS[heading], Q2.8 format (256 = 1.0)
angle_Y  out  10 signed  SIN[heading], Q2.8 format
update_done  out  1  one-cycle pulse at the end of each update
busy  out  1  high whenever the FSM is not in S_IDLE

Behaviour:
- Reset (async):
  - playerX=START_X, playerY=START_Y, heading=START_HEADING, with angle_X/angle_Y taken from the table for that heading.
  - map_addr=0, update_done=0, state=S_IDLE.
  - A reset during an update aborts it; no partial commit survives.
- Tables:
  - SIN[h] = round(256*sin(2*pi*h/32)).
  - COS[h] = SIN[(h+8) mod 32].
  - Both are 32-entry constants; angle_X/angle_Y are registered and follow heading.
- Edge detection: frame_tick is registered. A rising edge seen in S_IDLE starts an update. Rising edges seen while busy are ignored.
- S_TURN (1 cycle):
  - turn_left only: heading = heading+1 mod 32.
  - turn_right only: heading = heading-1 mod 32.
  - Both or neither: heading unchanged.
- S_CAND (1 cycle):
  - stepX = COS[new heading] >>> STEP_SHIFT; stepY = SIN[new heading] >>> STEP_SHIFT. The shift is arithmetic, so it floors.
  - fwd only: candidate = P + step. back only: candidate = P - step.
  - Both or neither: go to S_DONE with no move.
  - The three ordered attempts are A=(Xn,Yn), B=(Xn,Y), C=(X,Yn).
- Attempt sequence, for each attempt in order A, B, C:
  - The attempt is rejected without a ROM read if any coordinate is outside 0..1023, or if it equals the current position.
  - Otherwise S_READ drives map_addr = {Ycand[9:6], Xcand[9:6]}, and S_CHECK samples map_data on the next cycle.
  - map_data=0: commit the candidate to playerX/playerY, then go to S_DONE.
  - map_data=1: try the next attempt.
  - If all three attempts are rejected, go to S_DONE with position unchanged.
- S_DONE: update_done=1 for exactly one cycle, then return to S_IDLE.
- Worst-case latency from the tick edge to update_done is 9 cycles.
- playerX/playerY change only at a commit. Heading changes only in S_TURN.

Test Plan:
1. Empty map, reset, move_fwd=1, one tick -> playerX=112, playerY=96; update_done pulses once within 9 cycles; angle_X=256, angle_Y=0.
2. Heading 31, turn_left=1, one tick -> heading 0, angle_X=256, angle_Y=0. Heading 0, turn_right=1 -> heading 31, angle_X=251, angle_Y=-50.
3. Wall at addr 0x12, heading 0, pos (120,96), move_fwd -> A=(136,96) is blocked; B is the same cell and blocked; C equals the current position and is skipped; position stays (120,96), update_done=1.
4. Sliding: wall at 0x12, heading 4 (181,181), pos (120,100), move_fwd -> A=(131,111) blocked, B=(131,100) blocked, C=(120,111) free; commit (120,111).
5. Boundary: pos (1020,96), heading 0, move_fwd -> candidate X=1036 is out of range; position is unchanged. Heading 16, move_fwd from (8,96) -> X=-8 is rejected. Heading 4, move_back from (96,96) -> step -12, giving (84,84).
6. Tick pulses while busy are ignored (exactly one update_done per accepted edge). Asserting resetn=0 in S_CHECK -> outputs return to reset values immediately, with no commit.
